// File: rtl/mem_access_stage.sv
// Memory access stage: sits between EX/MEM and MEM/WB. Issues one data-memory
// access per load/store over a req/ack handshake, lane-aligns store data and
// byte enables, extends load data, and stalls the pipeline while the access
// is outstanding. Misaligned, illegal and timed-out accesses raise mem_fault.
module mem_access_stage #(
  parameter int datawidth = 32,
  parameter int regindex  = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  input  logic [datawidth-1:0] DataALU_in,
  input  logic [datawidth-1:0] store_data,
  input  logic [regindex-1:0]  regdindex_in,
  input  logic [1:0]           WBsel_in,
  input  logic                 Regwrite_in,
  input  logic [datawidth-1:0] PC_in,
  output logic [datawidth-1:0] DataMEM_out,
  output logic [datawidth-1:0] DataALU_out,
  output logic [regindex-1:0]  regdindex_out,
  output logic [1:0]           WBsel_out,
  output logic                 Regwrite_out,
  output logic [datawidth-1:0] PC_out,
  output logic                 stall,
  output logic                 mem_fault,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [datawidth-1:0] dmem_addr,
  output logic [datawidth-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic [datawidth-1:0] dmem_rdata,
  input  logic                 dmem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                 state;
  logic [TW-1:0]          timer;
  logic                   fault_r;
  logic [datawidth-1:0]   load_data;
  logic [1:0]             off_r;
  logic [2:0]             f3_r;

  logic                   op;
  logic                   bad;
  logic                   illegal_f3;
  logic                   misaligned;
  logic [3:0]             be_next;
  logic [datawidth-1:0]   wdata_next;
  logic [datawidth-1:0]   lane;
  logic [datawidth-1:0]   ext;

  assign DataALU_out   = DataALU_in;
  assign regdindex_out = regdindex_in;
  assign WBsel_out     = WBsel_in;
  assign PC_out        = PC_in;
  assign Regwrite_out  = Regwrite_in & ~mem_fault;

  assign op = valid_in & (mem_read | mem_write);

  // Classify the incoming access: illegal width, conflicting direction, misalignment
  always_comb begin
    illegal_f3 = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
      3'b100, 3'b101:         illegal_f3 = mem_write;
      default:                illegal_f3 = 1'b1;
    endcase
    misaligned = 1'b0;
    if (funct3[1:0] == 2'b10)
      misaligned = |DataALU_in[1:0];
    else if (funct3[1:0] == 2'b01)
      misaligned = DataALU_in[0];
    bad = illegal_f3 | (mem_read & mem_write) | misaligned;
  end

  // Byte enables and lane-replicated store data for the access being issued
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << DataALU_in[1:0];
        wdata_next = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_next    = DataALU_in[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{store_data[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = store_data;
      end
    endcase
  end

  // Shift the addressed lane down and sign/zero-extend it (offset/width latched at issue)
  always_comb begin
    lane = dmem_rdata >> {off_r, 3'b000};
    case (f3_r)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  // Access sequencer: issue in IDLE, wait for ack or timeout in BUSY, present result in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      load_data  <= '0;
      fault_r    <= 1'b0;
      timer      <= '0;
      off_r      <= '0;
      f3_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          fault_r <= 1'b0;
          timer   <= '0;
          if (op && !bad) begin
            state      <= BUSY;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {DataALU_in[datawidth-1:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
            off_r      <= DataALU_in[1:0];
            f3_r       <= funct3;
          end
        end
        BUSY: begin
          // Ack is tested first so an ack on the final allowed cycle is not a fault
          if (dmem_ack) begin
            load_data <= dmem_we ? '0 : ext;
            dmem_req  <= 1'b0;
            state     <= DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            load_data <= '0;
            fault_r   <= 1'b1;
            dmem_req  <= 1'b0;
            state     <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          fault_r <= 1'b0;
          timer   <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pipeline-facing status derived from the current state
  always_comb begin
    stall       = 1'b0;
    mem_fault   = 1'b0;
    DataMEM_out = '0;
    case (state)
      IDLE: begin
        stall     = op & ~bad;
        mem_fault = op & bad;
      end
      BUSY: stall = 1'b1;
      DONE: begin
        DataMEM_out = load_data;
        mem_fault   = fault_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of load/store vectors with
// hand-computed results, plus sequences for ALU pass-through and reset abort.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read, mem_write, Regwrite_in, dmem_ack;
  logic [2:0]  funct3;
  logic [31:0] DataALU_in, store_data, PC_in, dmem_rdata;
  logic [4:0]  regdindex_in;
  logic [1:0]  WBsel_in;
  logic [31:0] DataMEM_out, DataALU_out, PC_out, dmem_addr, dmem_wdata;
  logic [4:0]  regdindex_out;
  logic [1:0]  WBsel_out;
  logic        Regwrite_out, stall, mem_fault, dmem_req, dmem_we;
  logic [3:0]  dmem_be;

  int errors = 0;
  int checks = 0;

  mem_access_stage #(.datawidth(32), .regindex(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .DataALU_in(DataALU_in),
    .store_data(store_data), .regdindex_in(regdindex_in), .WBsel_in(WBsel_in),
    .Regwrite_in(Regwrite_in), .PC_in(PC_in), .DataMEM_out(DataMEM_out),
    .DataALU_out(DataALU_out), .regdindex_out(regdindex_out),
    .WBsel_out(WBsel_out), .Regwrite_out(Regwrite_out), .PC_out(PC_out),
    .stall(stall), .mem_fault(mem_fault), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, sd, rdata;
    logic        rw;
    int          ack_at;   // BUSY cycle carrying ack; 0 = never
    logic        bad;      // rejected in IDLE
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] dmem;
  } vec_t;

  function automatic vec_t mk(input string n, input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                              input logic rw, input int ack_at, input logic bad, input logic [3:0] be,
                              input logic [31:0] wdata, input logic chk_wdata, input logic [31:0] dmem);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata;
    v.rw = rw; v.ack_at = ack_at; v.bad = bad; v.be = be; v.wdata = wdata;
    v.chk_wdata = chk_wdata; v.dmem = dmem;
    return v;
  endfunction

  task automatic drive_idle();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    DataALU_in = '0; store_data = '0; Regwrite_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    bit expect_fault;
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
    DataALU_in = v.addr; store_data = v.sd; Regwrite_in = v.rw;
    regdindex_in = 5'd7; WBsel_in = 2'b01; PC_in = 32'h0000_4000 + v.addr;
    dmem_ack = 1'b0; dmem_rdata = v.rdata;
    @(negedge clk);
    check({v.name, "_passalu"}, DataALU_out, v.addr);
    if (v.bad) begin
      check({v.name, "_fault"}, {31'd0, mem_fault}, 32'd1);
      check({v.name, "_stall"}, {31'd0, stall}, 32'd0);
      check({v.name, "_regwr"}, {31'd0, Regwrite_out}, 32'd0);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check({v.name, "_noreq"}, {31'd0, dmem_req}, 32'd0);
      return;
    end
    check({v.name, "_issue_stall"}, {31'd0, stall}, 32'd1);
    check({v.name, "_issue_fault"}, {31'd0, mem_fault}, 32'd0);
    @(posedge clk); #1;
    check({v.name, "_req"}, {31'd0, dmem_req}, 32'd1);
    check({v.name, "_we"}, {31'd0, dmem_we}, {31'd0, v.wr});
    check({v.name, "_addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
    check({v.name, "_be"}, {28'd0, dmem_be}, {28'd0, v.be});
    if (v.chk_wdata) check({v.name, "_wdata"}, dmem_wdata, v.wdata);
    n = 0;
    forever begin
      n++;
      dmem_ack = (n == v.ack_at);
      @(negedge clk);
      if (!stall || n > 2 * TIMEOUT + 4) break;
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    expect_fault = (v.ack_at == 0);
    if (stall) begin
      errors++; checks++;
      $display("FAIL %s_timeout_bound: stall still high after %0d cycles", v.name, n);
      return;
    end
    check({v.name, "_stall_cycles"}, n, (v.ack_at == 0) ? 1 + TIMEOUT : 1 + v.ack_at);
    check({v.name, "_done_data"}, DataMEM_out, v.dmem);
    check({v.name, "_done_fault"}, {31'd0, mem_fault}, {31'd0, expect_fault});
    check({v.name, "_done_regwr"}, {31'd0, Regwrite_out}, {31'd0, v.rw & ~expect_fault});
    check({v.name, "_done_req"}, {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check({v.name, "_after_stall"}, {31'd0, stall}, 32'd0);
    check({v.name, "_after_data"}, DataMEM_out, 32'd0);
    check({v.name, "_after_req"}, {31'd0, dmem_req}, 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk("lw_100",   1, 0, 3'b010, 32'h100,  0,            32'hDEADBEEF, 1, 2,  0, 4'hF, 0, 0,            32'hDEADBEEF);
    vecs[1]  = mk("lb_101",   1, 0, 3'b000, 32'h101,  0,            32'h00008000, 1, 1,  0, 4'h2, 0, 0,            32'hFFFFFF80);
    vecs[2]  = mk("lbu_101",  1, 0, 3'b100, 32'h101,  0,            32'h00008000, 1, 1,  0, 4'h2, 0, 0,            32'h00000080);
    vecs[3]  = mk("lh_102",   1, 0, 3'b001, 32'h102,  0,            32'h80010000, 1, 1,  0, 4'hC, 0, 0,            32'hFFFF8001);
    vecs[4]  = mk("lhu_102",  1, 0, 3'b101, 32'h102,  0,            32'h80010000, 1, 3,  0, 4'hC, 0, 0,            32'h00008001);
    vecs[5]  = mk("lb_103",   1, 0, 3'b000, 32'h103,  0,            32'h7F000000, 1, 3,  0, 4'h8, 0, 0,            32'h0000007F);
    vecs[6]  = mk("sh_202",   0, 1, 3'b001, 32'h202,  32'h0000ABCD, 32'hFFFFFFFF, 0, 1,  0, 4'hC, 32'hABCDABCD, 1, 32'h0);
    vecs[7]  = mk("sb_203",   0, 1, 3'b000, 32'h203,  32'h123456A5, 32'hFFFFFFFF, 0, 2,  0, 4'h8, 32'hA5A5A5A5, 1, 32'h0);
    vecs[8]  = mk("sw_204",   0, 1, 3'b010, 32'h204,  32'hCAFEF00D, 32'hFFFFFFFF, 0, 1,  0, 4'hF, 32'hCAFEF00D, 1, 32'h0);
    vecs[9]  = mk("lw_mis",   1, 0, 3'b010, 32'h1001, 0,            0,            1, 1,  1, 4'h0, 0, 0,            0);
    vecs[10] = mk("lh_mis",   1, 0, 3'b001, 32'h103,  0,            0,            1, 1,  1, 4'h0, 0, 0,            0);
    vecs[11] = mk("ld_f3_011",1, 0, 3'b011, 32'h100,  0,            0,            1, 1,  1, 4'h0, 0, 0,            0);
    vecs[12] = mk("st_f3_100",0, 1, 3'b100, 32'h100,  0,            0,            0, 1,  1, 4'h0, 0, 0,            0);
    vecs[13] = mk("rd_and_wr",1, 1, 3'b010, 32'h100,  0,            0,            1, 1,  1, 4'h0, 0, 0,            0);
    vecs[14] = mk("lw_tmo",   1, 0, 3'b010, 32'h300,  0,            32'h12345678, 1, 0,  0, 4'hF, 0, 0,            32'h0);
    vecs[15] = mk("lw_ack16", 1, 0, 3'b010, 32'h300,  0,            32'h12345678, 1, 16, 0, 4'hF, 0, 0,            32'h12345678);

    rst = 1'b0;
    drive_idle();
    regdindex_in = 5'd0; WBsel_in = 2'b00; PC_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",   {31'd0, dmem_req}, 32'd0);
    check("rst_we",    {31'd0, dmem_we},  32'd0);
    check("rst_addr",  dmem_addr,  32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_be",    {28'd0, dmem_be}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_data",  DataMEM_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU op with stray ack: pure pass-through, no request
    @(posedge clk); #1;
    valid_in = 1'b1; DataALU_in = 32'h1234; Regwrite_in = 1'b1; dmem_ack = 1'b1;
    regdindex_in = 5'd9; WBsel_in = 2'b10; PC_in = 32'h0000_0080;
    @(negedge clk);
    check("alu_stall", {31'd0, stall}, 32'd0);
    check("alu_dataalu", DataALU_out, 32'h1234);
    check("alu_datamem", DataMEM_out, 32'd0);
    check("alu_regd", {27'd0, regdindex_out}, 32'd9);
    check("alu_wbsel", {30'd0, WBsel_out}, 32'd2);
    check("alu_pc", PC_out, 32'h80);
    check("alu_regwr", {31'd0, Regwrite_out}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("alu_noreq", {31'd0, dmem_req}, 32'd0);
    check("alu_nostall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    drive_idle();

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Reset during BUSY abandons the access; a late ack must not revive it
    @(posedge clk); #1;
    valid_in = 1'b1; mem_read = 1'b1; funct3 = 3'b010; DataALU_in = 32'h400; Regwrite_in = 1'b1;
    @(posedge clk); #1;
    check("rstbusy_req_before", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    #1;
    check("rstbusy_req_drop", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    check("rstbusy_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rstbusy_late_req", {31'd0, dmem_req}, 32'd0);
    check("rstbusy_late_data", DataMEM_out, 32'd0);
    check("rstbusy_late_stall", {31'd0, stall}, 32'd0);
    check("rstbusy_late_fault", {31'd0, mem_fault}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
